// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep block: sizes, reference table and FSM states.
package tt_pkg;

  localparam int N_IN_DEF = 7;
  localparam int TT_W_DEF = 2 ** N_IN_DEF;
  localparam int POP_W    = 8;

  localparam logic [TT_W_DEF-1:0] EXPECTED_DEF = 128'hfeeaeaa8eae8e8a8eae8e8a8eaa8a880;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/tt_sweep_dly.sv
// Shift line that carries {valid, idx} alongside the FUT pipeline.
// It is fed with the value x is about to take, so stage 0 mirrors x and
// the tail lines up with f_in after DUT_LAT further stages.
module tt_sweep_dly
  import tt_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int DUT_LAT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_idx,
  output logic            out_valid,
  output logic [N_IN-1:0] out_idx
);

  localparam int DEPTH = DUT_LAT + 1;

  logic [DEPTH-1:0] vld;
  logic [N_IN-1:0]  idx [DEPTH];

  // Advance the line every cycle; a flush empties it so an aborted sweep leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) idx[i] <= '0;
    end else if (flush) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) idx[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      idx[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_idx   = idx[DEPTH-1];

endmodule

// File: rtl/tt_sweep.sv
// Exhaustive truth-table extractor: walks x over every input vector of the
// function under test, captures its response and scores it against EXPECTED.
module tt_sweep
  import tt_pkg::*;
#(
  parameter int                     N_IN     = N_IN_DEF,
  parameter int                     DUT_LAT  = 0,
  parameter logic [(2**N_IN)-1:0]   EXPECTED = EXPECTED_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [N_IN-1:0]       x,
  input  logic                  f_in,
  output logic                  busy,
  output logic                  done,
  output logic [(2**N_IN)-1:0]  tt,
  output logic                  tt_valid,
  output logic [POP_W-1:0]      ones,
  output logic                  match,
  output logic                  mis_found,
  output logic [N_IN-1:0]       first_mis
);

  state_t          state, state_nx;
  logic [2:0]      drain_cnt;
  logic [N_IN-1:0] x_nx;
  logic            start_act, abort_act, cap_en;
  logic            tail_valid;
  logic [N_IN-1:0] tail_idx;

  // State register plus the drain counter that times the wait for the FUT pipeline to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      x         <= '0;
    end else begin
      state     <= state_nx;
      drain_cnt <= (state == DRAIN && state_nx == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      x         <= x_nx;
    end
  end

  // Next-state and next-stimulus logic; the last index ends the sweep instead of wrapping.
  always_comb begin
    state_nx = state;
    x_nx     = x;
    case (state)
      IDLE: begin
        if (start_act) begin
          state_nx = SWEEP;
          x_nx     = '0;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_nx = IDLE;
          x_nx     = '0;
        end else if (&x) begin
          state_nx = (DUT_LAT == 0) ? DONE : DRAIN;
        end else begin
          x_nx = x + 1'b1;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nx = IDLE;
          x_nx     = '0;
        end else if (drain_cnt == 3'(DUT_LAT - 1)) begin
          state_nx = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Decoded controls: abort outranks start, and only matters while a sweep is in flight.
  always_comb begin
    busy      = (state == SWEEP) || (state == DRAIN);
    abort_act = abort && busy;
    start_act = start && !abort && (state == IDLE);
    cap_en    = tail_valid && !abort_act;
    match     = tt_valid && !mis_found;
  end

  tt_sweep_dly #(
    .N_IN    (N_IN),
    .DUT_LAT (DUT_LAT)
  ) u_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort_act),
    .in_valid  (state_nx == SWEEP),
    .in_idx    (x_nx),
    .out_valid (tail_valid),
    .out_idx   (tail_idx)
  );

  // Result registers: cleared on start, filled from the line tail, published one cycle after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt        <= '0;
      ones      <= '0;
      mis_found <= 1'b0;
      first_mis <= '0;
      done      <= 1'b0;
      tt_valid  <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (start_act) begin
        tt        <= '0;
        ones      <= '0;
        mis_found <= 1'b0;
        first_mis <= '0;
        tt_valid  <= 1'b0;
      end else begin
        if (state == DONE) tt_valid <= 1'b1;
        if (cap_en) begin
          tt[tail_idx] <= f_in;
          ones         <= ones + POP_W'(f_in);
          if ((f_in != EXPECTED[tail_idx]) && !mis_found) begin
            mis_found <= 1'b1;
            first_mis <= tail_idx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_sweep.sv
// Self-checking bench for tt_sweep driving a 2-stage registered FUT model
// described by a plain lookup table.
module tb_tt_sweep;

  localparam int LAT = 2;
  localparam logic [127:0] EXP_TT = 128'hfeeaeaa8eae8e8a8eae8e8a8eaa8a880;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [6:0]   x;
  logic         f_in;
  logic         busy, done, tt_valid, match, mis_found;
  logic [127:0] tt;
  logic [7:0]   ones;
  logic [6:0]   first_mis;

  logic [127:0] fut_tbl = '0;
  logic         p1 = 1'b0;
  logic         p2 = 1'b0;

  int checks = 0;
  int errors = 0;

  tt_sweep #(
    .N_IN     (7),
    .DUT_LAT  (LAT),
    .EXPECTED (EXP_TT)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .x         (x),
    .f_in      (f_in),
    .busy      (busy),
    .done      (done),
    .tt        (tt),
    .tt_valid  (tt_valid),
    .ones      (ones),
    .match     (match),
    .mis_found (mis_found),
    .first_mis (first_mis)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Function under test: table lookup followed by two register stages.
  always @(posedge clk) begin
    p1 <= fut_tbl[x];
    p2 <= p1;
  end
  assign f_in = p2;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int refOnes(input logic [127:0] t);
    int n = 0;
    for (int i = 0; i < 128; i++) n += int'(t[i]);
    return n;
  endfunction

  function automatic int refFirst(input logic [127:0] t);
    for (int i = 0; i < 128; i++) if (t[i] !== EXP_TT[i]) return i;
    return -1;
  endfunction

  task automatic waitX(input string tag, input int target);
    int k = 0;
    while (x != 7'(target) && k < 300) begin
      nextCycle();
      k++;
    end
    checkOutput(tag, 128'(x), 128'(target));
  endtask

  task automatic waitNoDone(input string tag, input int n);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      nextCycle();
      if (done) seen = 1;
    end
    checkOutput(tag, 128'(seen), 0);
  endtask

  task automatic kickStart();
    nextCycle();
    applyStimulus(1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic runSweep(input string name);
    int  cnt = 0;
    bit  x_bad = 0;
    bit  busy_bad = 0;
    bit  got_done = 0;
    int  fm = refFirst(fut_tbl);
    kickStart();
    checkOutput({name, "_x0"}, 128'(x), 0);
    checkOutput({name, "_clr"}, 128'({tt_valid, busy}), 128'(2'b01));
    while (!got_done && cnt < 400) begin
      nextCycle();
      cnt++;
      if (cnt <= 130 && int'(x) != ((cnt < 128) ? cnt : 127)) x_bad = 1;
      if (busy != (cnt <= 129)) busy_bad = 1;
      if (done) got_done = 1;
    end
    checkOutput({name, "_lat"}, 128'(cnt), 128'(129 + LAT));
    checkOutput({name, "_xseq"}, 128'(x_bad), 0);
    checkOutput({name, "_busy"}, 128'(busy_bad), 0);
    checkOutput({name, "_tt"}, tt, fut_tbl);
    checkOutput({name, "_ones"}, 128'(ones), 128'(refOnes(fut_tbl)));
    checkOutput({name, "_mis"}, 128'(mis_found), 128'(fm >= 0));
    checkOutput({name, "_first"}, 128'(first_mis), 128'((fm >= 0) ? fm : 0));
    checkOutput({name, "_match"}, 128'(match), 128'(fm < 0));
    checkOutput({name, "_valid"}, 128'(tt_valid), 1);
    nextCycle();
    checkOutput({name, "_pulse"}, 128'({done, tt_valid}), 128'(2'b01));
  endtask

  // Main sequence.
  initial begin
    logic [127:0] t;
    #12;
    checkOutput("rst_tt", tt, 0);
    checkOutput("rst_misc", 128'({x, ones, first_mis, busy, done, tt_valid, match, mis_found}), 0);
    rst_n = 1'b1;

    fut_tbl = EXP_TT;
    runSweep("ref");

    for (int i = 0; i < 128; i++) t[i] = i[0];
    fut_tbl = t;
    runSweep("x0");

    fut_tbl = '0;
    runSweep("zero");

    fut_tbl = '1;
    runSweep("ones");

    for (int r = 0; r < 3; r++) begin
      fut_tbl = EXP_TT;
      fut_tbl[$urandom_range(127, 64)] ^= 1'b1;
      fut_tbl[$urandom_range(63, 0)]   ^= 1'b1;
      runSweep("flip");
      fut_tbl = {$urandom, $urandom, $urandom, $urandom};
      runSweep("rand");
    end

    // start and abort together in IDLE: abort wins, results untouched
    nextCycle();
    applyStimulus(1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    checkOutput("sa_idle", 128'({busy, tt_valid}), 128'(2'b01));
    waitNoDone("sa_nodone", 5);

    // start during sweep ignored, abort mid-sweep
    fut_tbl = {$urandom, $urandom, $urandom, $urandom};
    kickStart();
    waitX("ab_x10", 10);
    applyStimulus(1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    checkOutput("ab_ignore", 128'(x), 11);
    waitX("ab_x40", 40);
    applyStimulus(1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    checkOutput("ab_idle", 128'({busy, x}), 0);
    waitNoDone("ab_nodone", 140);
    checkOutput("ab_valid", 128'(tt_valid), 0);
    runSweep("after_ab");

    // abort while draining the FUT pipeline
    kickStart();
    waitX("dr_x127", 127);
    nextCycle();
    checkOutput("dr_busy", 128'(busy), 1);
    applyStimulus(1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    checkOutput("dr_idle", 128'({busy, x}), 0);
    waitNoDone("dr_nodone", 10);
    checkOutput("dr_valid", 128'(tt_valid), 0);

    // asynchronous reset in the middle of a sweep
    fut_tbl = EXP_TT;
    kickStart();
    waitX("rs_x70", 70);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rs_tt", tt, 0);
    checkOutput("rs_misc", 128'({x, ones, first_mis, busy, done, tt_valid, match, mis_found}), 0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    waitNoDone("rs_nodone", 3);
    runSweep("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
